store_buffer: RTL and testbench

Posted-store buffer between the MIPS core's data-memory port (`memwrite`, `dataadr`, `writedata`) and a slower data memory with a ready handshake. Stores retire into a small FIFO in one cycle and drain to memory in program order. When the FIFO is full, the block stalls the core. A compile-time option lets loads read the youngest buffered store to the same word.

---
 rtl/store_buffer.sv | 103 ++++++++++
 tb/tb_store_buffer.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/store_buffer.sv
// Posted-store buffer between the core data-memory port and a slower memory
// with a ready handshake. Stores enter a circular FIFO in one cycle and drain
// in program order; the core is stalled while the FIFO is full.
// Optional macro STORE_BUF_FWD_EN compiles in store-to-load forwarding of the
// youngest buffered store to the same word; otherwise fwd_hit_o/fwd_data_o are 0.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     memwrite_i,
  input  logic [AW-1:0]            dataadr_i,
  input  logic [DW-1:0]            writedata_i,
  output logic                     stall_o,
  output logic                     mem_we_o,
  output logic [AW-1:0]            mem_addr_o,
  output logic [DW-1:0]            mem_wdata_o,
  input  logic                     mem_ready_i,
  output logic                     fwd_hit_o,
  output logic [DW-1:0]            fwd_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [AW-1:0]   addr_q [DEPTH];
  logic [DW-1:0]   data_q [DEPTH];
  logic [PtrW-1:0] head_q, head_d;
  logic [PtrW-1:0] tail_q, tail_d;
  logic [CntW-1:0] count_q, count_d;

  logic full, empty, push, pop;

  assign full  = (count_q == CntW'(DEPTH));
  assign empty = (count_q == '0);
  // No write-through when full: a same-cycle pop does not free the slot early.
  assign push  = memwrite_i & ~full;
  assign pop   = ~empty & mem_ready_i;

  assign stall_o  = memwrite_i & full;
  assign mem_we_o = ~empty;
  // Head is gated so stale storage never shows after reset or when drained.
  assign mem_addr_o  = empty ? '0 : addr_q[head_q];
  assign mem_wdata_o = empty ? '0 : data_q[head_q];
  assign count_o     = count_q;

  // Next-state for pointers and occupancy; pointers wrap naturally (power of two).
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (pop)  head_d = head_q + PtrW'(1);
    if (push) tail_d = tail_q + PtrW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntW'(1);
      2'b01:   count_d = count_q - CntW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state with asynchronous active-low reset; clearing count invalidates all entries.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; validity is tracked by head/count, so payload needs no reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      addr_q[tail_q] <= dataadr_i;
      data_q[tail_q] <= writedata_i;
    end
  end

`ifdef STORE_BUF_FWD_EN
  // Scan oldest to youngest so the entry nearest the tail overrides earlier matches.
  always_comb begin
    fwd_hit_o  = 1'b0;
    fwd_data_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CntW'(i) < count_q) &&
          (addr_q[head_q + PtrW'(i)][AW-1:2] == dataadr_i[AW-1:2])) begin
        fwd_hit_o  = 1'b1;
        fwd_data_o = data_q[head_q + PtrW'(i)];
      end
    end
  end
`else
  assign fwd_hit_o  = 1'b0;
  assign fwd_data_o = '0;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed table, hand sequences for reset,
// concurrency and forwarding, then random traffic against a queue-based model.
module tb_store_buffer;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          memwrite;
  logic [AW-1:0] dataadr;
  logic [DW-1:0] writedata;
  logic          stall;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready;
  logic          fwd_hit;
  logic [DW-1:0] fwd_data;
  logic [2:0]    count;

  int checks = 0;
  int errors = 0;

  // Reference model: FIFO contents, oldest at index 0.
  logic [AW-1:0] mq_a[$];
  logic [DW-1:0] mq_d[$];

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] wd;
    logic          rdy;
    logic          e_stall;
    logic          e_we;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [2:0]    e_count;
  } vec_t;

  vec_t tbl[14];

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .memwrite_i  (memwrite),
    .dataadr_i   (dataadr),
    .writedata_i (writedata),
    .stall_o     (stall),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_ready_i (mem_ready),
    .fwd_hit_o   (fwd_hit),
    .fwd_data_o  (fwd_data),
    .count_o     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] wd,
                       input logic rdy);
    memwrite  = we;
    dataadr   = adr;
    writedata = wd;
    mem_ready = rdy;
    #1;
  endtask

  // Compare all outputs against the model for the current (pre-edge) cycle.
  task automatic model_check(input string tag);
    int n;
    logic          fh;
    logic [DW-1:0] fd;
    n  = mq_a.size();
    fh = 1'b0;
    fd = '0;
`ifdef STORE_BUF_FWD_EN
    for (int i = n - 1; i >= 0; i--) begin
      if (!fh && (mq_a[i][AW-1:2] == dataadr[AW-1:2])) begin
        fh = 1'b1;
        fd = mq_d[i];
      end
    end
`endif
    chk({tag, ".stall"}, 64'(stall), 64'(memwrite && (n == DEPTH)));
    chk({tag, ".mem_we"}, 64'(mem_we), 64'(n > 0));
    chk({tag, ".mem_addr"}, 64'(mem_addr), (n > 0) ? 64'(mq_a[0]) : 64'd0);
    chk({tag, ".mem_wdata"}, 64'(mem_wdata), (n > 0) ? 64'(mq_d[0]) : 64'd0);
    chk({tag, ".count"}, 64'(count), 64'(n));
    chk({tag, ".fwd_hit"}, 64'(fwd_hit), 64'(fh));
    chk({tag, ".fwd_data"}, 64'(fwd_data), 64'(fd));
  endtask

  // Advance the model by the rules of one clock edge, then cross the edge.
  task automatic model_step();
    logic do_pop, do_push;
    do_pop  = (mq_a.size() > 0) && mem_ready;
    do_push = memwrite && (mq_a.size() < DEPTH);
    if (do_pop) begin
      void'(mq_a.pop_front());
      void'(mq_d.pop_front());
    end
    if (do_push) begin
      mq_a.push_back(dataadr);
      mq_d.push_back(writedata);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input string tag, input logic we, input logic [AW-1:0] adr,
                     input logic [DW-1:0] wd, input logic rdy);
    apply(we, adr, wd, rdy);
    model_check(tag);
    model_step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    apply(1'b0, '0, '0, 1'b0);
    mq_a.delete();
    mq_d.delete();
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Single store, then fill to full with a stalled fifth store and drain in order.
    tbl[0]  = '{1'b1, 32'd84, 32'd241, 1'b1, 1'b0, 1'b0, 32'd0,  32'd0,   3'd0};
    tbl[1]  = '{1'b0, 32'd0,  32'd0,   1'b1, 1'b0, 1'b1, 32'd84, 32'd241, 3'd1};
    tbl[2]  = '{1'b0, 32'd0,  32'd0,   1'b1, 1'b0, 1'b0, 32'd0,  32'd0,   3'd0};
    tbl[3]  = '{1'b1, 32'd80, 32'd1,   1'b0, 1'b0, 1'b0, 32'd0,  32'd0,   3'd0};
    tbl[4]  = '{1'b1, 32'd84, 32'd2,   1'b0, 1'b0, 1'b1, 32'd80, 32'd1,   3'd1};
    tbl[5]  = '{1'b1, 32'd88, 32'd3,   1'b0, 1'b0, 1'b1, 32'd80, 32'd1,   3'd2};
    tbl[6]  = '{1'b1, 32'd92, 32'd4,   1'b0, 1'b0, 1'b1, 32'd80, 32'd1,   3'd3};
    tbl[7]  = '{1'b1, 32'd96, 32'd5,   1'b0, 1'b1, 1'b1, 32'd80, 32'd1,   3'd4};
    tbl[8]  = '{1'b1, 32'd96, 32'd5,   1'b1, 1'b1, 1'b1, 32'd80, 32'd1,   3'd4};
    tbl[9]  = '{1'b1, 32'd96, 32'd5,   1'b1, 1'b0, 1'b1, 32'd84, 32'd2,   3'd3};
    tbl[10] = '{1'b0, 32'd0,  32'd0,   1'b1, 1'b0, 1'b1, 32'd88, 32'd3,   3'd3};
    tbl[11] = '{1'b0, 32'd0,  32'd0,   1'b1, 1'b0, 1'b1, 32'd92, 32'd4,   3'd2};
    tbl[12] = '{1'b0, 32'd0,  32'd0,   1'b1, 1'b0, 1'b1, 32'd96, 32'd5,   3'd1};
    tbl[13] = '{1'b0, 32'd0,  32'd0,   1'b1, 1'b0, 1'b0, 32'd0,  32'd0,   3'd0};

    rst_n = 1'b0;
    apply(1'b0, '0, '0, 1'b0);
    chk("reset.mem_we", 64'(mem_we), 64'd0);
    chk("reset.count", 64'(count), 64'd0);
    do_reset();

    for (int i = 0; i < 14; i++) begin
      apply(tbl[i].we, tbl[i].adr, tbl[i].wd, tbl[i].rdy);
      chk($sformatf("tbl%0d.stall", i), 64'(stall), 64'(tbl[i].e_stall));
      chk($sformatf("tbl%0d.mem_we", i), 64'(mem_we), 64'(tbl[i].e_we));
      chk($sformatf("tbl%0d.mem_addr", i), 64'(mem_addr), 64'(tbl[i].e_addr));
      chk($sformatf("tbl%0d.mem_wdata", i), 64'(mem_wdata), 64'(tbl[i].e_wdata));
      chk($sformatf("tbl%0d.count", i), 64'(count), 64'(tbl[i].e_count));
      model_step();
    end

    // Reset mid-drain: three entries pending, reset pulsed between edges.
    for (int i = 0; i < 3; i++) cyc("fill", 1'b1, 32'(100 + 4 * i), 32'(i + 11), 1'b0);
    apply(1'b0, 32'd104, '0, 1'b0);
    chk("middrain.count_pre", 64'(count), 64'd3);
    rst_n = 1'b0;
    #1;
    mq_a.delete();
    mq_d.delete();
    chk("middrain.stall", 64'(stall), 64'd0);
    chk("middrain.mem_we", 64'(mem_we), 64'd0);
    chk("middrain.mem_addr", 64'(mem_addr), 64'd0);
    chk("middrain.mem_wdata", 64'(mem_wdata), 64'd0);
    chk("middrain.fwd_hit", 64'(fwd_hit), 64'd0);
    chk("middrain.fwd_data", 64'(fwd_data), 64'd0);
    chk("middrain.count", 64'(count), 64'd0);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) cyc("postrst", 1'b0, 32'd104, '0, 1'b1);

    // Concurrent push and pop from count 1 for 10 cycles; wraps the pointers.
    cyc("conc.seed", 1'b1, 32'd200, 32'd1000, 1'b0);
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 32'(204 + 4 * i), 32'(1001 + i), 1'b1);
      chk($sformatf("conc%0d.count", i), 64'(count), 64'd1);
      model_check("conc");
      model_step();
    end
    for (int i = 0; i < 2; i++) cyc("conc.drain", 1'b0, '0, '0, 1'b1);

    // Forwarding: two stores to the same word, youngest must win.
    cyc("fwd.s0", 1'b1, 32'd84, 32'd7, 1'b0);
    cyc("fwd.s1", 1'b1, 32'd84, 32'd9, 1'b0);
    apply(1'b0, 32'd86, '0, 1'b0);
`ifdef STORE_BUF_FWD_EN
    chk("fwd.hit86", 64'(fwd_hit), 64'd1);
    chk("fwd.data86", 64'(fwd_data), 64'd9);
`else
    chk("fwd.hit86", 64'(fwd_hit), 64'd0);
    chk("fwd.data86", 64'(fwd_data), 64'd0);
`endif
    apply(1'b0, 32'd88, '0, 1'b0);
    chk("fwd.hit88", 64'(fwd_hit), 64'd0);
    chk("fwd.data88", 64'(fwd_data), 64'd0);
    model_check("fwd");
    model_step();
    for (int i = 0; i < 3; i++) cyc("fwd.drain", 1'b0, '0, '0, 1'b1);

    // Random traffic on a small address window so forwarding hits are common.
    for (int i = 0; i < 400; i++) begin
      cyc("rand", ($urandom_range(0, 3) != 0),
          32'(80 + 4 * $urandom_range(0, 3) + $urandom_range(0, 3)),
          32'($urandom), ($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
